// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states, ALU opcodes and the
// latched command record. Widths here fix the command record layout.
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 32;
  localparam int SEQ_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic                  imm;
    logic [SEQ_ADDR_W-1:0] rs1;
    logic [SEQ_ADDR_W-1:0] rs2;
    logic [SEQ_ADDR_W-1:0] rd;
    logic [1:0]            op;
    logic [SEQ_DATA_W-1:0] immdata;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between a command source (master)
// and the ALU command sequencer (slave).
interface alu_cmd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both 1; once raised, valid and its payload hold until that edge.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_imm;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] cmd_rd;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_immdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_imm, cmd_rs1, cmd_rs2, cmd_rd, cmd_op, cmd_immdata,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_imm, cmd_rs1, cmd_rs2, cmd_rd, cmd_op, cmd_immdata,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences register-file reads, ALU opcode and write-back for one command at
// a time. Optional macro ALU_SEQ_R0_PROTECT_EN suppresses writes to register 0.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_cmd_if.slave          cmd,
  output logic [ADDR_W-1:0] a1,
  output logic [ADDR_W-1:0] a2,
  output logic [ADDR_W-1:0] a3,
  output logic              we3,
  output logic [DATA_W-1:0] wd3,
  output logic [1:0]        sopcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CNT_W-1:0]  op_count,
  output seq_state_e        state_dbg,
  output cmd_t              cmd_dbg
);

  seq_state_e        state_q, state_d;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] a1_q, a2_q, a3_q;
  logic [1:0]        sop_q;
  logic [DATA_W-1:0] wd3_q;
  logic              accept, rsp_fire;
  logic              drop_imm, drop_cmd;

`ifdef ALU_SEQ_R0_PROTECT_EN
  assign drop_imm = (cmd.cmd_rd == '0);
  assign drop_cmd = (cmd_q.rd == '0);
`else
  assign drop_imm = 1'b0;
  assign drop_cmd = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    cmd.cmd_ready  = 1'b0;
    cmd.rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) state_d = cmd.cmd_imm ? WRITE : EXEC;
      end
      EXEC:  state_d = WRITE;
      WRITE: state_d = RESP;
      RESP: begin
        cmd.rsp_valid = 1'b1;
        if (cmd.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = cmd.cmd_valid && (state_q == IDLE);
  assign rsp_fire = cmd.rsp_valid && cmd.rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= '0;
      result_q <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      sop_q    <= '0;
      wd3_q    <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        cmd_q <= '{imm: cmd.cmd_imm, rs1: cmd.cmd_rs1, rs2: cmd.cmd_rs2,
                   rd: cmd.cmd_rd, op: cmd.cmd_op, immdata: cmd.cmd_immdata};
        if (cmd.cmd_imm) result_q <= drop_imm ? '0 : cmd.cmd_immdata;
      end
      if (state_q == EXEC) begin
        a1_q     <= cmd_q.rs1;
        a2_q     <= cmd_q.rs2;
        sop_q    <= cmd_q.op;
        result_q <= drop_cmd ? '0 : alu_result;
      end
      if (state_q == WRITE) begin
        a3_q  <= cmd_q.rd;
        wd3_q <= result_q;
      end
      if (rsp_fire) op_count <= op_count + CNT_W'(1);
    end
  end

  // Address/opcode/data buses show the live command in their own state and
  // otherwise hold whatever they last presented.
  assign a1      = (state_q == EXEC)  ? cmd_q.rs1 : a1_q;
  assign a2      = (state_q == EXEC)  ? cmd_q.rs2 : a2_q;
  assign sopcode = (state_q == EXEC)  ? cmd_q.op  : sop_q;
  assign a3      = (state_q == WRITE) ? cmd_q.rd  : a3_q;
  assign wd3     = (state_q == WRITE) ? result_q  : wd3_q;
  assign we3     = (state_q == WRITE) && !drop_cmd;

  assign cmd.rsp_data = result_q;
  assign state_dbg    = state_q;
  assign cmd_dbg      = cmd_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural register file/ALU; honours
// ALU_SEQ_R0_PROTECT_EN for the register-0 expectations.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic [AW-1:0] a1, a2, a3;
  logic          we3;
  logic [DW-1:0] wd3, alu_result;
  logic [1:0]    sopcode;
  logic [CW-1:0] op_count;
  seq_state_e    state_dbg;
  cmd_t          cmd_dbg;

  alu_cmd_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (bus),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .we3        (we3),
    .wd3        (wd3),
    .sopcode    (sopcode),
    .alu_result (alu_result),
    .op_count   (op_count),
    .state_dbg  (state_dbg),
    .cmd_dbg    (cmd_dbg)
  );

  // Register file (sync write, comb read) and ALU
  logic [DW-1:0] regs [32] = '{default: '0};
  always @(posedge clk) if (we3) regs[a3] <= wd3;
  always_comb begin
    alu_result = '0;
    case (sopcode)
      OP_ADD: alu_result = regs[a1] + regs[a2];
      OP_SUB: alu_result = regs[a1] - regs[a2];
      OP_AND: alu_result = regs[a1] & regs[a2];
      OP_OR:  alu_result = regs[a1] | regs[a2];
      default: alu_result = '0;
    endcase
  end

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int we3_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]    exp_q[$];
  logic [AW+DW-1:0] wr_q[$];
  int               lat_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event with empty expected queue (t=%0t)", name, $time);
  endtask

  // Monitor: samples 2ns after each falling edge, pops and compares
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (bus.rsp_valid && !prev_valid) begin
        if (lat_q.size() == 0) unexpected("rsp_latency");
        else check("rsp_latency", 64'(cyc), 64'(lat_q.pop_front()));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) unexpected("rsp_data");
        else check("rsp_data", 64'(bus.rsp_data), 64'(exp_q.pop_front()));
      end
      if (we3) begin
        we3_cnt++;
        if (wr_q.size() == 0) unexpected("write");
        else check("write_a3_wd3", 64'({a3, wd3}), 64'(wr_q.pop_front()));
      end
    end
    prev_valid = bus.rsp_valid;
  end

  // Issues one command; returns at the falling edge just after acceptance
  task automatic send(input logic imm, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                      input logic [AW-1:0] rd, input logic [1:0] op, input logic [DW-1:0] data,
                      input logic [DW-1:0] exp_rsp, input logic exp_we);
    int acc;
    exp_q.push_back(exp_rsp);
    if (exp_we) wr_q.push_back({rd, exp_rsp});
    bus.cmd_imm     = imm;
    bus.cmd_rs1     = rs1;
    bus.cmd_rs2     = rs2;
    bus.cmd_rd      = rd;
    bus.cmd_op      = op;
    bus.cmd_immdata = data;
    bus.cmd_valid   = 1'b1;
    acc = -1;
    for (int t = 0; t < 20; t++) begin
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      unexpected("accept_timeout");
    end else begin
      lat_q.push_back(acc + (imm ? 2 : 3));
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) unexpected("rsp_timeout");
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data), 64'd0);
    check("rst_a1_a2_a3",  64'({a1, a2, a3}), 64'd0);
    check("rst_we3_wd3",   64'({we3, wd3}), 64'd0);
    check("rst_sopcode",   64'(sopcode), 64'd0);
    check("rst_op_count",  64'(op_count), 64'd0);
    check("rst_state",     64'(state_dbg), 64'(IDLE));
  endtask

  int we_before;
  logic [DW-1:0] r0_exp;
  logic          r0_we;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_imm = 1'b0;
    bus.cmd_rs1 = '0;
    bus.cmd_rs2 = '0;
    bus.cmd_rd = '0;
    bus.cmd_op = '0;
    bus.cmd_immdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // Immediate load r1 = 5, observed in its WRITE cycle
    send(1'b1, 5'd0, 5'd0, 5'd1, OP_ADD, 32'h5, 32'h5, 1'b1);
    check("imm_write_pulse", 64'({we3, a3, wd3}), 64'({1'b1, 5'd1, 32'h5}));
    wait_done();
    check("op_count_1", 64'(op_count), 64'd1);
    send(1'b1, 5'd0, 5'd0, 5'd2, OP_ADD, 32'h3, 32'h3, 1'b1);
    wait_done();

    // ALU operations, EXEC bus values checked for ADD
    send(1'b0, 5'd1, 5'd2, 5'd3, OP_ADD, 32'h0, 32'h8, 1'b1);
    check("exec_state", 64'(state_dbg), 64'(EXEC));
    check("exec_a1_a2_op", 64'({a1, a2, sopcode}), 64'({5'd1, 5'd2, OP_ADD}));
    wait_done();
    send(1'b0, 5'd2, 5'd1, 5'd3, OP_SUB, 32'h0, 32'hFFFF_FFFE, 1'b1);
    wait_done();
    send(1'b0, 5'd1, 5'd2, 5'd4, OP_AND, 32'h0, 32'h1, 1'b1);
    wait_done();

    // Response back-pressure with a competing command offered
    bus.rsp_ready = 1'b0;
    we_before = we3_cnt;
    send(1'b0, 5'd1, 5'd2, 5'd5, OP_OR, 32'h0, 32'h7, 1'b1);
    for (int t = 0; t < 10; t++) begin
      if (bus.rsp_valid) break;
      @(negedge clk);
    end
    bus.cmd_imm = 1'b1;
    bus.cmd_rd = 5'd6;
    bus.cmd_immdata = 32'h77;
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      check("stall_rsp", 64'({bus.rsp_valid, bus.rsp_data}), 64'({1'b1, 32'h7}));
      check("stall_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("stall_single_we3", 64'(we3_cnt - we_before), 64'd1);
    bus.rsp_ready = 1'b1;
    wait_done();
    check("op_count_6", 64'(op_count), 64'd6);

    // Reset while in EXEC aborts the command
    send(1'b0, 5'd1, 5'd2, 5'd6, OP_ADD, 32'h0, 32'h8, 1'b1);
    reset_n = 1'b0;
    exp_q.delete();
    wr_q.delete();
    lat_q.delete();
    #1;
    check_reset_outputs();
    we_before = we3_cnt;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_write", 64'(we3_cnt - we_before), 64'd0);
    check("abort_r6_untouched", 64'(regs[6]), 64'd0);

    send(1'b0, 5'd1, 5'd2, 5'd6, OP_ADD, 32'h0, 32'h8, 1'b1);
    wait_done();
    check("post_reset_count", 64'(op_count), 64'd1);

    // Source equals destination: r1 = r1 + r2
    send(1'b0, 5'd1, 5'd2, 5'd1, OP_ADD, 32'h0, 32'h8, 1'b1);
    wait_done();
    check("rs_eq_rd_r1", 64'(regs[1]), 64'd8);

`ifdef ALU_SEQ_R0_PROTECT_EN
    r0_exp = 32'h0;
    r0_we  = 1'b0;
`else
    r0_exp = 32'hDEAD_BEEF;
    r0_we  = 1'b1;
`endif
    send(1'b1, 5'd0, 5'd0, 5'd0, OP_ADD, 32'hDEAD_BEEF, r0_exp, r0_we);
    check("r0_we3", 64'(we3), 64'(r0_we));
    wait_done();
    check("op_count_3", 64'(op_count), 64'd3);

    // Counter wraparound
    for (int i = 0; i < (1 << CW) - 4; i++) begin
      send(1'b1, 5'd0, 5'd0, 5'((i % 31) + 1), OP_ADD, DW'(i), DW'(i), 1'b1);
      wait_done();
    end
    check("op_count_max", 64'(op_count), 64'((1 << CW) - 1));
    send(1'b1, 5'd0, 5'd0, 5'd9, OP_ADD, 32'h1234, 32'h1234, 1'b1);
    wait_done();
    check("op_count_wrap", 64'(op_count), 64'd0);
    check("queues_drained", 64'(exp_q.size() + wr_q.size() + lat_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    checks++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side initiator for the register-file/ALU datapath. It accepts register-level operation commands over a valid/ready handshake and sequences the datapath's read ports, ALU opcode and write port over multiple cycles. Each result is written back into the register file and returned on a response handshake. It sits above the datapath and drives every signal the datapath consumes: A1, A2, A3, WE3, WD3 and Sopcode.

Parameters:
- DATA_W, 32, datapath word width.
- ADDR_W, 5, register address width (32 registers).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_IMM  in  1  1 = load CMD_IMMDATA into rd; 0 = ALU operation.
- CMD_RS1, CMD_RS2, CMD_RD  in  ADDR_W each  source and destination registers.
- CMD_OP  in  2  ALU opcode (Sopcode).
- CMD_IMMDATA  in  DATA_W  immediate value.
- A1, A2, A3  out  ADDR_W each  register file addresses.
- WE3  out  1  register file write enable.
- WD3  out  DATA_W  register file write data.
- SOPCODE  out  2  ALU opcode.
- ALU_RESULT  in  DATA_W  ALU output (combinational from RD1/RD2).
- RSP_VALID  out  1  result available.
- RSP_READY  in  1  consumer accepts the result.
- RSP_DATA  out  DATA_W  value written to rd.
- OP_COUNT  out  CNT_W  completed operations.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state=IDLE; all outputs 0 except CMD_READY=1.
  - Latched command and result registers are cleared.
  - Reset asserted in any state aborts the operation immediately; no partial write follows.
- FSM states: IDLE, EXEC, WRITE, RESP.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID&CMD_READY, latch all CMD_* fields.
  - If CMD_IMM=1: result<=CMD_IMMDATA and go to WRITE.
  - Otherwise go to EXEC.
- EXEC:
  - Drive A1=rs1, A2=rs2, SOPCODE=op.
  - Register ALU_RESULT into the result register at the end of the cycle; go to WRITE.
- WRITE:
  - WE3=1 for exactly one cycle, with A3=rd and WD3=result; go to RESP.
- RESP:
  - RSP_VALID=1, RSP_DATA=result.
  - RSP_VALID and RSP_DATA stay stable until RSP_READY=1; then go to IDLE.
  - OP_COUNT increments by 1 on the handshake cycle and wraps modulo 2^CNT_W.
- CMD_READY=0 in every state except IDLE. There is no command overlap and no hazards.
- Latency from the accept cycle, with RSP_READY held high:
  - ALU command: RSP_VALID asserted 3 cycles after accept.
  - Immediate command: RSP_VALID asserted 2 cycles after accept.
- Default drives:
  - Outside EXEC, A1, A2 and SOPCODE hold their last driven values.
  - Outside WRITE, WE3=0; A3 and WD3 hold their last values.
- rs1==rd or rs2==rd is legal: the read happens in EXEC, strictly before the write in WRITE.
- The register file write is synchronous and its read is combinational. The ALU opcodes are 00 add, 01 sub, 10 and, 11 or.

Optional Feature:
- Macro: ALU_SEQ_R0_PROTECT_EN.
- When defined: a command with rd==0 runs the full sequence, but WE3 stays 0 in WRITE. RSP_DATA reports 0 and OP_COUNT still increments.
- When undefined: register 0 is written like any other register.

Decomposition:
- Shared package alu_seq_pkg holds:
  - the state enum (IDLE/EXEC/WRITE/RESP);
  - the opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR;
  - a command struct {imm, rs1, rs2, rd, op, immdata}.
- No sub-module. The FSM and its registers form a single module.
- The verification top instantiates alu_cmd_sequencer together with the existing register-file/ALU datapath.

Test Plan:
- Reset, then IMM load rd=1 data=0x0000_0005 → WE3 pulse with A3=1, WD3=5; RSP_DATA=5 two cycles after accept; OP_COUNT=1.
- Load r1=5, r2=3; ADD rs1=1 rs2=2 rd=3 → in EXEC, A1=1, A2=2, SOPCODE=00; WRITE has WD3=8; RSP_DATA=8 three cycles after accept.
- SUB r3=r2-r1 (3-5) → RSP_DATA=0xFFFF_FFFE. Then AND r4=r1&r2 → RSP_DATA=1.
- Hold RSP_READY=0 for 5 cycles → RSP_VALID and RSP_DATA stable; CMD_READY=0; a CMD_VALID in that window is not accepted; WE3 pulses only once.
- Assert RESET_N=0 during EXEC → on reset all outputs go to 0 and CMD_READY=1; no WE3 pulse follows; a subsequent command completes normally.
- rd=0 IMM 0xDEAD_BEEF:
  - with ALU_SEQ_R0_PROTECT_EN: WE3 stays 0 and RSP_DATA=0;
  - without the macro: WE3=1 and RSP_DATA=0xDEAD_BEEF.
  - Also preload OP_COUNT to 0xFFFF via 65535 operations; the next completion gives OP_COUNT=0.
